// File: rtl/game_pkg.sv
// Shared game definitions: direction encodings, opposite-direction helper and
// the movement scheduler state encoding.
package game_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } sched_state_t;

  // Up/down and left/right differ only in bit 0.
  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    return dir ^ 2'b01;
  endfunction

endpackage

// File: rtl/dir_pick.sv
// Combinational lowest-index selector over a 4-bit request mask, with bits in
// excl removed from consideration before selection.
module dir_pick (
  input  logic [3:0] mask,
  input  logic [3:0] excl,
  output logic       valid,
  output logic [1:0] dir
);

  logic [3:0] eff;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_eff
      assign eff[gi] = mask[gi] & ~excl[gi];
    end
  endgenerate

  assign valid = |eff;

  always_comb begin
    dir = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eff[i]) dir = 2'(i);
    end
  end

endmodule

// File: rtl/dir_step_scheduler.sv
// Arbitrates four debounced direction buttons into frame-aligned step pulses:
// immediate first step, hold delay, then auto-repeat.
// Optional: define DIR_REVERSE_BLOCK_EN to ignore the direction opposite last_dir.
module dir_step_scheduler
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY = 15,
  parameter int REPEAT_RATE  = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] btn,
  input  logic       frame_tick,
  output logic       step,
  output logic [1:0] step_dir,
  output logic [1:0] last_dir,
  output logic       held
);

  sched_state_t     state_reg, state_next;
  logic [1:0]       active_reg, active_next;
  logic             pending_reg, pending_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]       btn_q_reg;
  logic             step_reg, step_next;
  logic [1:0]       step_dir_reg, last_dir_reg;
  logic             held_reg, held_next;

  logic [3:0] rise, excl;
  logic       rise_valid, cand_valid;
  logic [1:0] rise_dir, cand_dir;

  assign rise    = btn & ~btn_q_reg;
  assign cnt_inc = cnt_reg + 1'b1;

`ifdef DIR_REVERSE_BLOCK_EN
  assign excl = 4'b0001 << opposite_dir(last_dir_reg);
`else
  assign excl = 4'b0000;
`endif

  dir_pick u_pick_rise (
    .mask  (rise),
    .excl  (excl),
    .valid (rise_valid),
    .dir   (rise_dir)
  );

  // Fallback candidates: every held, non-excluded button.
  dir_pick u_pick_held (
    .mask  (btn),
    .excl  (excl),
    .valid (cand_valid),
    .dir   (cand_dir)
  );

  always_comb begin
    state_next   = state_reg;
    active_next  = active_reg;
    pending_next = pending_reg;
    cnt_next     = cnt_reg;
    step_next    = 1'b0;

    if (!enable) begin
      state_next   = IDLE;
      pending_next = 1'b0;
      cnt_next     = '0;
    end else if (rise_valid) begin
      active_next  = rise_dir;
      pending_next = 1'b1;
      state_next   = FIRST;
      cnt_next     = '0;
    end else if (!cand_valid) begin
      state_next   = IDLE;
      pending_next = 1'b0;
      cnt_next     = '0;
    end else if (state_reg != IDLE && !btn[active_reg]) begin
      // Active button let go while others remain: hand over to the next one.
      active_next  = cand_dir;
      pending_next = 1'b1;
      state_next   = FIRST;
      cnt_next     = '0;
    end else if (frame_tick) begin
      case (state_reg)
        FIRST: begin
          if (pending_reg) begin
            step_next    = 1'b1;
            pending_next = 1'b0;
            cnt_next     = '0;
            state_next   = DELAY;
          end
        end
        DELAY: begin
          if (cnt_inc == CNT_W'(REPEAT_DELAY)) begin
            step_next  = 1'b1;
            cnt_next   = '0;
            state_next = REPEAT;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        REPEAT: begin
          if (cnt_inc == CNT_W'(REPEAT_RATE)) begin
            step_next = 1'b1;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: ;
      endcase
    end

    held_next = (state_next != IDLE) && btn[active_next];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      active_reg   <= DIR_UP;
      pending_reg  <= 1'b0;
      cnt_reg      <= '0;
      btn_q_reg    <= 4'b0000;
      step_reg     <= 1'b0;
      step_dir_reg <= DIR_UP;
      last_dir_reg <= DIR_UP;
      held_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      active_reg  <= active_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      btn_q_reg   <= btn;
      step_reg    <= step_next;
      held_reg    <= held_next;
      if (step_next) begin
        step_dir_reg <= active_reg;
        last_dir_reg <= active_reg;
      end
    end
  end

  assign step     = step_reg;
  assign step_dir = step_dir_reg;
  assign last_dir = last_dir_reg;
  assign held     = held_reg;

endmodule

// File: tb/tb_dir_step_scheduler.sv
// Directed bench for dir_step_scheduler: per-cycle vector table plus frame-level
// sequences for hold/repeat, handover, enable drop and mid-sequence reset.
module tb_dir_step_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] btn;
  logic       frame_tick;
  logic       step;
  logic [1:0] step_dir;
  logic [1:0] last_dir;
  logic       held;

  int n_pass  = 0;
  int n_total = 0;
  int stray   = 0;

  dir_step_scheduler #(
    .REPEAT_DELAY (15),
    .REPEAT_RATE  (4),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .btn        (btn),
    .frame_tick (frame_tick),
    .step       (step),
    .step_dir   (step_dir),
    .last_dir   (last_dir),
    .held       (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       tick;
    logic       exp_step;
    logic [1:0] exp_dir;
    logic       exp_held;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %s ok (%0h)", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame: a tick cycle followed by nine quiet cycles; any step in the
  // quiet cycles is counted as a stray pulse.
  task automatic frame(output logic got, output logic [1:0] d, output logic h);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    got = step;
    d   = step_dir;
    h   = held;
    repeat (9) begin
      @(negedge clk);
      if (step !== 1'b0) stray++;
    end
  endtask

  initial begin
    logic       g;
    logic [1:0] d;
    logic       h;
    logic       exp_s;

    rst        = 1'b0;
    enable     = 1'b1;
    btn        = 4'b0000;
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_step", 8'(step), 8'd0);
    chk("reset_step_dir", 8'(step_dir), 8'd0);
    chk("reset_last_dir", 8'(last_dir), 8'd0);
    chk("reset_held", 8'(held), 8'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Hold up: steps on frames 1, 16, then every 4th frame.
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    for (int f = 1; f <= 28; f++) begin
      frame(g, d, h);
      exp_s = (f inside {1, 16, 20, 24, 28}) ? 1'b1 : 1'b0;
      $display("hold frame %0d: step=%0b dir=%0d held=%0b", f, g, d, h);
      chk($sformatf("hold_step_f%0d", f), 8'(g), 8'(exp_s));
      if (exp_s) chk($sformatf("hold_dir_f%0d", f), 8'(d), 8'd0);
      chk($sformatf("hold_held_f%0d", f), 8'(h), 8'd1);
    end
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    chk("release_held", 8'(held), 8'd0);

    //           btn      tick  step  dir   held
    vecs[0]  = '{4'b0110, 1'b0, 1'b0, 2'd0, 1'b1}; // two rises: down wins
    vecs[1]  = '{4'b0110, 1'b1, 1'b1, 2'd1, 1'b1};
    vecs[2]  = '{4'b0110, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{4'b1000, 1'b1, 1'b0, 2'd0, 1'b1}; // press with tick: not consumed
    vecs[5]  = '{4'b1000, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[6]  = '{4'b1000, 1'b1, 1'b1, 2'd3, 1'b1};
    vecs[7]  = '{4'b1000, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0}; // release with tick: release wins
    vecs[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[10] = '{4'b1000, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[11] = '{4'b1010, 1'b0, 1'b0, 2'd0, 1'b1}; // down press preempts right
    vecs[12] = '{4'b1010, 1'b1, 1'b1, 2'd1, 1'b1};
    vecs[13] = '{4'b1000, 1'b0, 1'b0, 2'd0, 1'b1}; // down released: fall back to right
    vecs[14] = '{4'b1000, 1'b1, 1'b1, 2'd3, 1'b1};

    for (int i = 0; i < 15; i++) begin
      btn        = vecs[i].btn;
      frame_tick = vecs[i].tick;
      @(negedge clk);
      frame_tick = 1'b0;
      $display("vec %0d: btn=%b tick=%0b -> step=%0b dir=%0d held=%0b",
               i, vecs[i].btn, vecs[i].tick, step, step_dir, held);
      chk($sformatf("vec%0d_step", i), 8'(step), 8'(vecs[i].exp_step));
      if (vecs[i].exp_step) chk($sformatf("vec%0d_dir", i), 8'(step_dir), 8'(vecs[i].exp_dir));
      chk($sformatf("vec%0d_held", i), 8'(held), 8'(vecs[i].exp_held));
    end

    // Right after handover: 15-frame delay before the first repeat.
    for (int f = 1; f <= 15; f++) begin
      frame(g, d, h);
      exp_s = (f == 15) ? 1'b1 : 1'b0;
      $display("handover frame %0d: step=%0b dir=%0d", f, g, d);
      chk($sformatf("handover_step_f%0d", f), 8'(g), 8'(exp_s));
      if (exp_s) chk("handover_dir", 8'(d), 8'd3);
    end
    chk("handover_last_dir", 8'(last_dir), 8'd3);

    // Drop enable while repeating, then re-enable with right still held.
    enable = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      frame(g, d, h);
      $display("disabled frame %0d: step=%0b held=%0b", f, g, h);
      chk($sformatf("disabled_step_f%0d", f), 8'(g), 8'd0);
      chk($sformatf("disabled_held_f%0d", f), 8'(h), 8'd0);
    end
    enable = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      frame(g, d, h);
      $display("reenabled frame %0d: step=%0b held=%0b", f, g, h);
      chk($sformatf("reenabled_step_f%0d", f), 8'(g), 8'd0);
      chk($sformatf("reenabled_held_f%0d", f), 8'(h), 8'd0);
    end

    // Left press, first step, then reset while the pulse is high.
    btn = 4'b1100;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("pre_reset_step", 8'(step), 8'd1);
    chk("pre_reset_dir", 8'(step_dir), 8'd2);
    chk("pre_reset_last_dir", 8'(last_dir), 8'd2);
    #1 rst = 1'b0;
    #1;
    $display("mid-sequence reset: step=%0b dir=%0d last=%0d held=%0b", step, step_dir, last_dir, held);
    chk("midreset_step", 8'(step), 8'd0);
    chk("midreset_step_dir", 8'(step_dir), 8'd0);
    chk("midreset_last_dir", 8'(last_dir), 8'd0);
    chk("midreset_held", 8'(held), 8'd0);
    btn = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

`ifdef DIR_REVERSE_BLOCK_EN
    btn = 4'b0100;
    @(negedge clk);
    frame(g, d, h);
    chk("rb_left_step", 8'(g), 8'd1);
    chk("rb_left_dir", 8'(d), 8'd2);
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    btn = 4'b1000;
    @(negedge clk);
    frame(g, d, h);
    chk("rb_right_blocked_step", 8'(g), 8'd0);
    chk("rb_right_blocked_held", 8'(h), 8'd0);
    btn = 4'b1001;
    @(negedge clk);
    frame(g, d, h);
    chk("rb_up_step", 8'(g), 8'd1);
    chk("rb_up_dir", 8'(d), 8'd0);
`endif

    chk("no_stray_steps", 8'(stray), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dir_step_scheduler.md
Name: dir_step_scheduler

Overview:
- Sits between the four per-button debouncers and the sprite/snake position logic in the VGA game.
- Takes four debounced direction levels and arbitrates them to a single active direction.
- Sequences movement as one-cycle step pulses aligned to the frame tick: an immediate first step, then a hold delay, then auto-repeat.
- The position datapath consumes step_dir only when step is high.

Parameters:
- REPEAT_DELAY, 15, frame ticks between the first step and the first auto-repeat step (must be >= 1).
- REPEAT_RATE, 4, frame ticks between successive auto-repeat steps (must be >= 1).
- CNT_W, 8, frame counter width; REPEAT_DELAY and REPEAT_RATE must be < 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  game running; low forces IDLE.
- btn  input  4  debounced levels: bit0 up, bit1 down, bit2 left, bit3 right.
- frame_tick  input  1  one-cycle pulse per frame (start of vsync).
- step  output  1  one-cycle movement pulse.
- step_dir  output  2  direction for step: 0 up, 1 down, 2 left, 3 right.
- last_dir  output  2  direction of the most recent emitted step.
- held  output  1  high while the active direction's button is held.

Behaviour:
- Reset (rst=0):
  - step=0, step_dir=0, last_dir=0, held=0.
  - State=IDLE, pending=0, frame_cnt=0, btn_q=0.
- Edge detect: btn_q <= btn every cycle; rise = btn & ~btn_q.
- Arbitration (evaluated every cycle while enable=1):
  - Any rise bit set: active_dir <= lowest-index rising bit, pending <= 1, state <= FIRST. This applies in any state; a new press preempts repeat.
  - Else, active button released (btn[active_dir]=0) and other bits held: active_dir <= lowest-index held bit, pending <= 1, state <= FIRST.
  - Else, no button held: state <= IDLE, pending <= 0.
- States:
  - IDLE: waits for a press.
  - FIRST: on frame_tick with pending=1, emit a step, pending <= 0, frame_cnt <= 0, state <= DELAY.
  - DELAY: each frame_tick increments frame_cnt. When the incremented value equals REPEAT_DELAY, emit a step, frame_cnt <= 0, state <= REPEAT.
  - REPEAT: each frame_tick increments frame_cnt. When the incremented value equals REPEAT_RATE, emit a step and frame_cnt <= 0.
- Step emission:
  - Outputs are registered: step=1 and step_dir=active_dir in the cycle after the frame_tick is sampled.
  - last_dir updates in the same cycle as step.
  - step is never high for two consecutive cycles.
- Press and frame_tick in the same cycle: the press is registered (pending set), but that tick is not consumed. The first step occurs on the next frame_tick.
- Release and frame_tick in the same cycle: the release wins and no step is emitted.
- held = (state != IDLE) and btn[active_dir]; registered.
- enable=0: step forced 0, state=IDLE, pending=0, frame_cnt=0. btn_q keeps tracking btn, so buttons held across re-enable do not produce a rise.
- Reset asserted mid-sequence: immediate return to reset values, with no partial step pulse.
- frame_cnt never wraps: it is cleared on every emitted step and on every state change.

Optional Feature:
- Macro: DIR_REVERSE_BLOCK_EN.
- Defined: a candidate direction that is the opposite of last_dir (up/down, left/right) is ignored by arbitration.
  - A rise on the opposite bit is not latched.
  - Fallback selection skips it.
  - If it is the only held button, state goes to IDLE.
  - This blocks the snake from reversing into itself.
- Undefined: every direction is accepted as described above.

Decomposition:
- Shared package (game_pkg) holds:
  - direction encodings DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_LEFT=2'd2, DIR_RIGHT=2'd3;
  - the opposite-direction function (dir ^ 2'b01);
  - the state encodings IDLE/FIRST/DELAY/REPEAT.
- One sub-module is natural: dir_pick, a combinational lowest-index selector over a 4-bit mask (with an optional exclusion mask), used for both the rise and fallback paths.

Test Plan:
- Press btn=4'b0001 and hold; frame_tick every 10 clk. Expect a step with dir 0 one cycle after the first tick, the next step after tick 16, then every 4th tick. held=1 throughout.
- Press btn=4'b0110 in one cycle. Expect active_dir=1 (down), and the first step after the next tick with step_dir=1.
- Hold down, then release down while right stays held. Expect a switch to dir 3, state FIRST, and a step at the next tick followed by the 15-tick delay.
- Press coincident with frame_tick. Expect no step on that tick and a step after the following tick.
- Drop enable mid-REPEAT, then raise it again with the button still held. Expect no steps and IDLE. Drive rst=0 mid-DELAY and expect all outputs 0 at once.
- With DIR_REVERSE_BLOCK_EN, last_dir=2 (left), press right alone. Expect no step and held=0. A subsequent up press gives a step with dir 0.
